// File: rtl/dma_burst_ram.sv
// dma_burst_ram: DEPTH x DATA_W buffer moving valid/ready bursts between memory and streams.
// Optional macro DMA_WRAP_EN: bursts wrap modulo DEPTH instead of being rejected at the top.
module dma_burst_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              read_signal,
  input  logic              write_signal,
  input  logic [ADDR_W-1:0] address,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              dataout_valid,
  input  logic              dataout_ready,
  output logic              busy,
  output logic              doneRead,
  output logic              doneWrite,
  output logic              err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_FETCH  = 3'd1,
    S_RD_HOLD   = 3'd2,
    S_WR_ACCEPT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, addr_nxt_s;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dataout_q, dataout_d;
  logic                dataout_valid_q, dataout_valid_d;
  logic                data_ready_q, data_ready_d;
  logic                done_rd_q, done_rd_d;
  logic                done_wr_q, done_wr_d;
  logic                err_q, err_d;
  logic                reject_s;
  logic                wr_en_s;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
`ifdef DMA_WRAP_EN
    if ({1'b0, a} == (DEPTH_L - (ADDR_W+1)'(1))) begin
      return {ADDR_W{1'b0}};
    end else begin
      return a + ADDR_W'(1);
    end
`else
    return a + ADDR_W'(1);
`endif
  endfunction

`ifdef DMA_WRAP_EN
  assign reject_s = ({1'b0, address} >= DEPTH_L);
`else
  logic [ADDR_W:0] sum_s;
  // Sum is one bit wider than the address so a large start plus length cannot overflow.
  assign sum_s    = {1'b0, address} + (ADDR_W+1)'(burst_len);
  assign reject_s = ({1'b0, address} >= DEPTH_L) || (sum_s > DEPTH_L);
`endif

  assign addr_nxt_s = addr_inc(addr_q);
  assign wr_en_s    = (state_q == S_WR_ACCEPT) && data_valid && data_ready_q;

  // Buffer storage: no reset so contents survive RST.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[addr_q[IDX_W-1:0]] <= data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q         <= S_IDLE;
      addr_q          <= {ADDR_W{1'b0}};
      cnt_q           <= {LEN_W{1'b0}};
      dataout_q       <= {DATA_W{1'b0}};
      dataout_valid_q <= 1'b0;
      data_ready_q    <= 1'b0;
      done_rd_q       <= 1'b0;
      done_wr_q       <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      dataout_q       <= dataout_d;
      dataout_valid_q <= dataout_valid_d;
      data_ready_q    <= data_ready_d;
      done_rd_q       <= done_rd_d;
      done_wr_q       <= done_wr_d;
      err_q           <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    dataout_d       = dataout_q;
    dataout_valid_d = dataout_valid_q;
    data_ready_d    = data_ready_q;
    done_rd_d       = 1'b0;
    done_wr_d       = 1'b0;
    err_d           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read_signal || write_signal) begin
          if (reject_s) begin
            err_d = 1'b1;
          end else if (burst_len == {LEN_W{1'b0}}) begin
            state_d   = S_DONE;
            done_rd_d = read_signal;
            done_wr_d = !read_signal;
          end else begin
            addr_d       = address;
            cnt_d        = burst_len;
            state_d      = read_signal ? S_RD_FETCH : S_WR_ACCEPT;
            data_ready_d = !read_signal;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_FETCH: begin
        dataout_d       = mem_q[addr_q[IDX_W-1:0]];
        dataout_valid_d = 1'b1;
        state_d         = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (dataout_ready) begin
          addr_d = addr_nxt_s;
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            dataout_valid_d = 1'b0;
            done_rd_d       = 1'b1;
            state_d         = S_DONE;
          end else begin
            // Next word is loaded on the handshake edge for 1 word/cycle throughput.
            dataout_d = mem_q[addr_nxt_s[IDX_W-1:0]];
          end
        end else begin
          state_d = S_RD_HOLD;
        end
      end
      S_WR_ACCEPT: begin
        if (wr_en_s) begin
          addr_d = addr_nxt_s;
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            data_ready_d = 1'b0;
            done_wr_d    = 1'b1;
            state_d      = S_DONE;
          end else begin
            state_d = S_WR_ACCEPT;
          end
        end else begin
          state_d = S_WR_ACCEPT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d         = S_IDLE;
        dataout_valid_d = 1'b0;
        data_ready_d    = 1'b0;
      end
    endcase
  end

  assign data_ready    = data_ready_q;
  assign dataout       = dataout_q;
  assign dataout_valid = dataout_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign doneRead      = done_rd_q;
  assign doneWrite     = done_wr_q;
  assign err           = err_q;

endmodule
